// File: rtl/icon_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icon_loader_pkg
// Description : Shared constants for the RojoBot icon path. The icon loader,
//               the icon draw logic and the icon RAM (depth BLANK_ADDR+1) all
//               take their geometry and the blank-pixel location from here.
//               Also holds the loader state encoding.
// Contents    : ICON_WIDTH, ICON_HEIGHT  - icon geometry in pixels
//               BLANK_ADDR               - RAM word read for off-icon pixels
//               TRANSPARENT              - colour code treated as see-through
//               state_t                  - loader FSM state encoding
// Revision    : 1.0 - initial release
// ============================================================================
package icon_loader_pkg;

  localparam int ICON_WIDTH  = 15;
  localparam int ICON_HEIGHT = 15;

  localparam logic [7:0] BLANK_ADDR  = 8'd226;
  localparam logic [7:0] TRANSPARENT = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_BLANK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage : icon_loader_pkg
`default_nettype wire

// File: rtl/icon_loader_raster_ctr.sv
`default_nettype none
// ============================================================================
// Module      : icon_raster_ctr
// Description : Raster-order pixel position counter. Tracks column and row,
//               and keeps the linear RAM index as a running count alongside
//               them so no multiplier is needed. Wraps to (0,0) after the last
//               pixel of the icon.
// Ports       : clk    in   system clock
//               reset  in   asynchronous reset, active-high
//               clr    in   synchronous clear back to pixel 0
//               en     in   advance one pixel
//               index  out  linear index row*WIDTH+col of the current pixel
//               last   out  current pixel is the final one of the icon
// Revision    : 1.0 - initial release
// ============================================================================
module icon_raster_ctr #(
  parameter int WIDTH  = 15,
  parameter int HEIGHT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  output logic [7:0] index,
  output logic       last
);

  localparam logic [7:0] c_COL_MAX = 8'(WIDTH - 1);
  localparam logic [7:0] c_ROW_MAX = 8'(HEIGHT - 1);

  logic [7:0] r_col;
  logic [7:0] r_row;
  logic [7:0] r_index;
  logic       w_col_end;
  logic       w_last;

  assign w_col_end = (r_col == c_COL_MAX);
  assign w_last    = w_col_end && (r_row == c_ROW_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col   <= 8'd0;
      r_row   <= 8'd0;
      r_index <= 8'd0;
    end else if (clr) begin
      r_col   <= 8'd0;
      r_row   <= 8'd0;
      r_index <= 8'd0;
    end else if (en) begin
      if (w_col_end) begin
        r_col <= 8'd0;
        r_row <= (r_row == c_ROW_MAX) ? 8'd0 : r_row + 8'd1;
      end else begin
        r_col <= r_col + 8'd1;
      end
      // The linear index follows the raster walk directly, so it only needs
      // to restart when the whole icon has been traversed.
      r_index <= w_last ? 8'd0 : r_index + 8'd1;
    end
  end

  assign index = r_index;
  assign last  = w_last;

endmodule : icon_raster_ctr
`default_nettype wire

// File: rtl/icon_loader.sv
`default_nettype none
// ============================================================================
// Module      : icon_loader
// Description : Streams 8-bit colour codes from the CPU I/O port into write
//               port A of the dual-port icon RAM in raster order, then writes
//               the transparent colour to BLANK_ADDR. The draw side (port B)
//               is not touched.
// Ports       : clk        in   system clock
//               reset      in   asynchronous reset, active-high
//               start      in   1-cycle pulse: begin or restart a load
//               pix_data   in   colour code of the next pixel
//               pix_valid  in   pix_data valid this cycle
//               pix_ready  out  loader accepts pix_data this cycle
//               ram_we     out  icon RAM write enable
//               ram_addr   out  icon RAM write address
//               ram_din    out  icon RAM write data
//               busy       out  load in progress
//               done       out  sticky load-complete flag, cleared by start
//               pix_count  out  pixels accepted in the current load
// Revision    : 1.0 - initial release
// ============================================================================
module icon_loader
  import icon_loader_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] pix_data,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic       ram_we,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_din,
  output logic       busy,
  output logic       done,
  output logic [7:0] pix_count
);

  state_t     r_state;
  logic       r_pix_ready;
  logic       r_ram_we;
  logic [7:0] r_ram_addr;
  logic [7:0] r_ram_din;
  logic       r_busy;
  logic       r_done;
  logic [7:0] r_pix_count;

  logic       w_xfer;
  logic [7:0] w_index;
  logic       w_last;

  // A start pulse takes priority over a simultaneous handshake: the pixel
  // offered on that edge is dropped rather than written at the old address.
  assign w_xfer = pix_valid && r_pix_ready && !start;

  icon_raster_ctr #(
    .WIDTH  (ICON_WIDTH),
    .HEIGHT (ICON_HEIGHT)
  ) u_raster_ctr (
    .clk   (clk),
    .reset (reset),
    .clr   (start),
    .en    (w_xfer),
    .index (w_index),
    .last  (w_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_pix_ready <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= 8'd0;
      r_ram_din   <= 8'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pix_count <= 8'd0;
    end else begin
      // Write strobe is a single-cycle pulse; address and data simply hold.
      r_ram_we <= 1'b0;

      if (start) begin
        // Valid from any state, including aborting an active load. A write
        // already on the RAM port this cycle still lands.
        r_state     <= ST_LOAD;
        r_pix_ready <= 1'b1;
        r_busy      <= 1'b1;
        r_done      <= 1'b0;
        r_pix_count <= 8'd0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            r_state <= ST_IDLE;
          end

          ST_LOAD: begin
            if (w_xfer) begin
              r_ram_we    <= 1'b1;
              r_ram_addr  <= w_index;
              r_ram_din   <= pix_data;
              r_pix_count <= r_pix_count + 8'd1;
              if (w_last) begin
                r_state     <= ST_BLANK;
                r_pix_ready <= 1'b0;
              end
            end
          end

          ST_BLANK: begin
            r_ram_we   <= 1'b1;
            r_ram_addr <= BLANK_ADDR;
            r_ram_din  <= TRANSPARENT;
            r_state    <= ST_DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
          end

          ST_DONE: begin
            r_state <= ST_DONE;
          end

          default: begin
            r_state     <= ST_IDLE;
            r_pix_ready <= 1'b0;
            r_busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pix_ready = r_pix_ready;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_din   = r_ram_din;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pix_count = r_pix_count;

endmodule : icon_loader
`default_nettype wire
